// File: rtl/params_pkg.sv
// params_pkg: shared widths and the decode-to-scoreboard issue request layout.
package params_pkg;
   localparam int REGISTER_WIDTH = 5;
   localparam int MAX_LATENCY    = 8;
   localparam int LAT_W          = $clog2(MAX_LATENCY + 1);

   typedef struct packed {
      logic [REGISTER_WIDTH-1:0] rs1;
      logic                      rs1_needed;
      logic [REGISTER_WIDTH-1:0] rs2;
      logic                      rs2_needed;
      logic [REGISTER_WIDTH-1:0] rd;
      logic                      rd_we;
      logic                      is_mem;
      logic [LAT_W-1:0]          latency;
   } issue_req_t;
endpackage

// File: rtl/sb_entry.sv
// sb_entry: remaining fixed latency and outstanding-load flag for one architectural register.
module sb_entry #(
   parameter int LAT_W = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_freeze,
   input  logic             i_set_lat,
   input  logic [LAT_W-1:0] i_lat,
   input  logic             i_set_mem,
   input  logic             i_clr_mem,
   output logic [LAT_W-1:0] o_lat,
   output logic             o_mem
);
   logic [LAT_W-1:0] r_lat;
   logic             r_mem;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_lat <= '0;
         r_mem <= 1'b0;
      end else begin
         if (i_set_lat) r_lat <= i_lat;
         else if (!i_freeze && r_lat != '0) r_lat <= r_lat - 1'b1;
         if (i_set_mem) r_mem <= 1'b1;
         else if (i_clr_mem) r_mem <= 1'b0;
      end
   end

   assign o_lat = r_lat;
   assign o_mem = r_mem;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register pending-write scoreboard raising RAW, WAW and
// writeback-port stalls for decode; fixed-latency writebacks reserve slots in r_slot.
module hazard_scoreboard #(
   parameter int REGISTER_WIDTH = params_pkg::REGISTER_WIDTH,
   parameter int MAX_LATENCY    = params_pkg::MAX_LATENCY,
   parameter bit BYPASS_LAST    = 1'b1
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         dec_valid_i,
   input  params_pkg::issue_req_t       issue_req_i,
   input  logic                         freeze_i,
   input  logic                         mem_wb_valid_i,
   input  logic [REGISTER_WIDTH-1:0]    mem_wb_reg_i,
   output logic                         stall_decode_o,
   output logic                         stall_fetch_o,
   output logic                         issue_bubble_o,
   output logic                         raw_hazard_o,
   output logic                         waw_hazard_o,
   output logic                         struct_hazard_o,
   output logic [2**REGISTER_WIDTH-1:0] pending_o
);
   localparam int NUM_REGS = 2**REGISTER_WIDTH;
   localparam int LAT_W    = $clog2(MAX_LATENCY + 1);
   localparam logic [LAT_W-1:0] RAW_THR = LAT_W'(BYPASS_LAST);
   import params_pkg::*;

   logic [LAT_W-1:0]          w_lat [NUM_REGS];
   logic [NUM_REGS-1:0]       w_mem;
   logic [MAX_LATENCY:1]      r_slot, w_slot_n;
   logic [REGISTER_WIDTH-1:0] w_rs1, w_rs2, w_rd;
   logic [LAT_W-1:0]          w_l;
   logic w_illegal, w_fixed, w_var, w_slot_hit, w_raw, w_waw, w_struct, w_stall, w_fire;

   assign w_rs1 = REGISTER_WIDTH'(issue_req_i.rs1);
   assign w_rs2 = REGISTER_WIDTH'(issue_req_i.rs2);
   assign w_rd  = REGISTER_WIDTH'(issue_req_i.rd);
   assign w_l   = LAT_W'(issue_req_i.latency);

   assign w_lat[0] = '0;
   assign w_mem[0] = 1'b0;
   for (genvar g = 1; g < NUM_REGS; g++) begin : g_entry
      sb_entry #(.LAT_W(LAT_W)) u_entry (
         .i_clk     (clk_i),
         .i_rst_n   (rst_ni),
         .i_freeze  (freeze_i),
         .i_set_lat (w_fire & w_fixed & (w_rd == REGISTER_WIDTH'(g))),
         .i_lat     (w_l),
         .i_set_mem (w_fire & w_var & (w_rd == REGISTER_WIDTH'(g))),
         .i_clr_mem (mem_wb_valid_i & (mem_wb_reg_i == REGISTER_WIDTH'(g))),
         .o_lat     (w_lat[g]),
         .o_mem     (w_mem[g])
      );
   end

   always_comb for (int r = 0; r < NUM_REGS; r++) pending_o[r] = (w_lat[r] != '0) | w_mem[r];

   assign w_illegal = dec_valid_i & ~issue_req_i.is_mem & ((w_l == '0) | (w_l > LAT_W'(MAX_LATENCY)));
   assign w_fixed   = issue_req_i.rd_we & ~issue_req_i.is_mem & ~w_illegal;
   assign w_var     = issue_req_i.rd_we & issue_req_i.is_mem;

   always_comb begin
      w_slot_hit = 1'b0;
      for (int j = 1; j <= MAX_LATENCY; j++) if (w_l == LAT_W'(j)) w_slot_hit = r_slot[j];
   end

   assign w_raw = (issue_req_i.rs1_needed & (w_rs1 != '0) & (w_mem[w_rs1] | (w_lat[w_rs1] > RAW_THR)))
                | (issue_req_i.rs2_needed & (w_rs2 != '0) & (w_mem[w_rs2] | (w_lat[w_rs2] > RAW_THR)));
   // An older write with lat_q == L lands one cycle before ours, so ordering already holds.
   assign w_waw = issue_req_i.rd_we & (w_rd != '0)
                & (issue_req_i.is_mem ? pending_o[w_rd] : (w_mem[w_rd] | (w_lat[w_rd] > w_l)));
   assign w_struct = w_illegal | (w_fixed & w_slot_hit);

   assign w_stall         = dec_valid_i & (w_raw | w_waw | w_struct | freeze_i);
   assign w_fire          = dec_valid_i & ~w_stall;
   assign stall_decode_o  = w_stall;
   assign stall_fetch_o   = w_stall;
   assign issue_bubble_o  = w_stall & dec_valid_i;
   assign raw_hazard_o    = dec_valid_i & w_raw;
   assign waw_hazard_o    = dec_valid_i & ~w_raw & w_waw;
   assign struct_hazard_o = dec_valid_i & ~w_raw & ~w_waw & w_struct;

   always_comb begin
      w_slot_n = r_slot >> 1;
      for (int j = 1; j < MAX_LATENCY; j++) if (w_fire & w_fixed & (w_l == LAT_W'(j + 1))) w_slot_n[j] = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_slot <= '0;
      else if (!freeze_i) r_slot <= w_slot_n;
   end

   a_legal_latency: assert property (@(posedge clk_i) disable iff (!rst_ni) !w_illegal);
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed decode sequences against write-through and non-bypass scoreboards.
module tb_hazard_scoreboard;
   import params_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, dec_valid, freeze, wb;
   logic [4:0]  wb_reg;
   issue_req_t  req;
   logic        s1, f1, b1, r1, w1, x1, s0, f0, b0, r0, w0, x0;
   logic [31:0] p1, p0;
   logic [5:0]  o1, o0;
   int          errors = 0, checks = 0;

   always #5 clk = ~clk;

   hazard_scoreboard #(.BYPASS_LAST(1'b1)) u_byp (
      .clk_i(clk), .rst_ni(rst_n), .dec_valid_i(dec_valid), .issue_req_i(req), .freeze_i(freeze),
      .mem_wb_valid_i(wb), .mem_wb_reg_i(wb_reg), .stall_decode_o(s1), .stall_fetch_o(f1),
      .issue_bubble_o(b1), .raw_hazard_o(r1), .waw_hazard_o(w1), .struct_hazard_o(x1), .pending_o(p1));

   hazard_scoreboard #(.BYPASS_LAST(1'b0)) u_nob (
      .clk_i(clk), .rst_ni(rst_n), .dec_valid_i(dec_valid), .issue_req_i(req), .freeze_i(freeze),
      .mem_wb_valid_i(wb), .mem_wb_reg_i(wb_reg), .stall_decode_o(s0), .stall_fetch_o(f0),
      .issue_bubble_o(b0), .raw_hazard_o(r0), .waw_hazard_o(w0), .struct_hazard_o(x0), .pending_o(p0));

   assign o1 = {s1, f1, b1, r1, w1, x1};
   assign o0 = {s0, f0, b0, r0, w0, x0};

   function automatic logic [5:0] e(input logic s, input logic r, input logic w, input logic x);
      return {s, s, s & dec_valid, r, w, x};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One decode cycle: drive at the falling edge, settle, then the caller checks.
   task automatic op(input logic v, input int rs1, input int rs2, input int rd, input logic mem,
                     input int lat, input logic fz = 1'b0, input logic w = 1'b0, input int wr = 0);
      @(negedge clk);
      dec_valid      = v;
      req.rs1        = 5'(rs1);
      req.rs1_needed = rs1 != 0;
      req.rs2        = 5'(rs2);
      req.rs2_needed = rs2 != 0;
      req.rd         = 5'(rd);
      req.rd_we      = rd != 0;
      req.is_mem     = mem;
      req.latency    = 4'(lat);
      freeze         = fz;
      wb             = w;
      wb_reg         = 5'(wr);
      #1;
   endtask

   task automatic idle();
      op(1'b0, 0, 0, 0, 1'b0, 1);
   endtask

   initial begin
      rst_n = 1'b0; dec_valid = 1'b0; req = '0; freeze = 1'b0; wb = 1'b0; wb_reg = '0;
      idle();
      chk("rst pending", p1, 32'h0);
      chk("rst outputs", 32'(o1), 32'(e(0, 0, 0, 0)));
      op(1'b1, 0, 0, 0, 1'b0, 1, 1'b1);
      chk("rst freeze stall", 32'(o1), 32'(e(1, 0, 0, 0)));
      rst_n = 1'b1;

      op(1'b1, 0, 0, 5, 1'b0, 1);
      chk("add x5", 32'(o1), 32'(e(0, 0, 0, 0)));
      op(1'b1, 5, 0, 6, 1'b0, 1);
      chk("sub bypass", 32'(o1), 32'(e(0, 0, 0, 0)));
      chk("sub nobypass", 32'(o0), 32'(e(1, 1, 0, 0)));
      op(1'b1, 5, 0, 6, 1'b0, 1);
      chk("sub nobypass retry", 32'(o0), 32'(e(0, 0, 0, 0)));
      repeat (3) idle();

      op(1'b1, 0, 0, 7, 1'b0, 4);
      chk("mul x7", 32'(o1), 32'(e(0, 0, 0, 0)));
      op(1'b1, 7, 0, 12, 1'b0, 1);
      chk("raw t+1", 32'(o1), 32'(e(1, 1, 0, 0)));
      chk("pending x7", 32'(p1[7]), 32'h1);
      op(1'b1, 7, 0, 12, 1'b0, 1);
      chk("raw t+2", 32'(o1), 32'(e(1, 1, 0, 0)));
      op(1'b1, 7, 0, 12, 1'b0, 1);
      chk("raw t+3", 32'(o1), 32'(e(1, 1, 0, 0)));
      op(1'b1, 7, 0, 12, 1'b0, 1);
      chk("raw t+4 free", 32'(o1), 32'(e(0, 0, 0, 0)));
      idle();
      chk("pending after mul", p1, 32'h0000_1000);
      idle();
      chk("pending drained", p1, 32'h0);

      op(1'b1, 0, 0, 8, 1'b0, 4);
      chk("mul x8", 32'(o1), 32'(e(0, 0, 0, 0)));
      op(1'b1, 0, 0, 8, 1'b0, 1);
      chk("waw t+1", 32'(o1), 32'(e(1, 0, 1, 0)));
      op(1'b1, 0, 0, 8, 1'b0, 1);
      op(1'b1, 0, 0, 8, 1'b0, 1);
      chk("waw t+3", 32'(o1), 32'(e(1, 0, 1, 0)));
      op(1'b1, 0, 0, 8, 1'b0, 1);
      chk("waw t+4 free", 32'(o1), 32'(e(0, 0, 0, 0)));
      idle();
      chk("pending x8 add", p1, 32'h0000_0100);
      idle();

      op(1'b1, 0, 0, 9, 1'b0, 3);
      chk("mul x9", 32'(o1), 32'(e(0, 0, 0, 0)));
      op(1'b1, 0, 0, 10, 1'b0, 2);
      chk("struct t+1", 32'(o1), 32'(e(1, 0, 0, 1)));
      op(1'b1, 0, 0, 10, 1'b0, 2);
      chk("struct t+2 free", 32'(o1), 32'(e(0, 0, 0, 0)));
      repeat (4) idle();
      chk("pending after struct", p1, 32'h0);

      op(1'b1, 0, 0, 11, 1'b1, 0);
      chk("lw x11", 32'(o1), 32'(e(0, 0, 0, 0)));
      op(1'b1, 0, 0, 13, 1'b0, 4);
      chk("mul x13", 32'(o1), 32'(e(0, 0, 0, 0)));
      op(1'b1, 0, 0, 16, 1'b0, 1, 1'b1);
      chk("freeze only", 32'(o1), 32'(e(1, 0, 0, 0)));
      chk("pending x11 x13", p1, 32'h0000_2800);
      for (int i = 0; i < 4; i++) begin
         op(1'b1, 11, 0, 14, 1'b0, 1, 1'b1);
         chk("frozen load dep", 32'(o1), 32'(e(1, 1, 0, 0)));
      end
      op(1'b1, 11, 0, 14, 1'b0, 1, 1'b0, 1'b1, 11);
      chk("mem_wb cycle", 32'(o1), 32'(e(1, 1, 0, 0)));
      op(1'b1, 11, 0, 14, 1'b0, 1);
      chk("after mem_wb", 32'(o1), 32'(e(0, 0, 0, 0)));
      op(1'b1, 13, 0, 15, 1'b0, 1);
      chk("lat held by freeze", 32'(o1), 32'(e(1, 1, 0, 0)));
      op(1'b1, 13, 0, 15, 1'b0, 1);
      chk("lat resumes", 32'(o1), 32'(e(0, 0, 0, 0)));
      repeat (3) idle();

      op(1'b1, 0, 0, 7, 1'b0, 4);
      op(1'b1, 0, 0, 11, 1'b1, 0);
      idle();
      chk("pre-reset pending", p1, 32'h0000_0880);
      rst_n = 1'b0;
      #1;
      chk("async reset pending", p1, 32'h0);
      chk("async reset pending nob", p0, 32'h0);
      idle();
      chk("reset outputs", 32'(o1), 32'(e(0, 0, 0, 0)));
      rst_n = 1'b1;
      op(1'b1, 7, 0, 12, 1'b0, 1);
      chk("dep after reset", 32'(o1), 32'(e(0, 0, 0, 0)));
      idle();
      chk("dep fired after reset", p1, 32'h0000_1000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
